// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, immediate-type encodings and the
// canonical NOP, plus the record a decode stage keeps per buffered entry.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // One decoded instruction as held in the main or skid slot.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } dec_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I format classification and immediate formation.
module imm_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_type_e   imm_type,
  output logic        illegal
);

  // Classify the instruction format from its opcode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
        OPC_STORE:                                  imm_type = IMM_S;
        OPC_BRANCH:                                 imm_type = IMM_B;
        OPC_LUI, OPC_AUIPC:                         imm_type = IMM_U;
        OPC_JAL:                                    imm_type = IMM_J;
        OPC_OP:                                     imm_type = IMM_NONE;
        default:                                    illegal  = 1'b1;
      endcase
    end
  end

  // Assemble the immediate for the classified format; illegal yields zero.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: decodes at capture and buffers up to two decoded
// entries (main + skid) so in_ready can be a registered signal.
module id_decode_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_type,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]  state_q, state_d;
  dec_entry_t  main_q, main_d;
  dec_entry_t  skid_q, skid_d;
  dec_entry_t  in_entry;
  logic [31:0] dec_imm;
  imm_type_e   dec_imm_type;
  logic        dec_illegal;
  logic        accept;
  logic        pop;

  imm_decode u_imm_decode (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_imm_type),
    .illegal  (dec_illegal)
  );

  // Pack the freshly decoded input into the storage record.
  always_comb begin
    in_entry.instr    = in_instr;
    in_entry.pc       = in_pc;
    in_entry.imm      = dec_imm;
    in_entry.imm_type = dec_imm_type;
    in_entry.rs1      = in_instr[19:15];
    in_entry.rs2      = in_instr[24:20];
    in_entry.rd       = in_instr[11:7];
    in_entry.illegal  = dec_illegal;
  end

  // Handshake qualifiers derived only from registered state.
  always_comb begin
    in_ready  = (state_q != ST_TWO);
    out_valid = (state_q != ST_EMPTY);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Occupancy transitions and slot moves; flush wins over everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy register; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry payload registers.
  always_ff @(posedge clk) begin
    // NOTE: payload slots are not reset; the outputs are masked while the
    // state is EMPTY, so stale slot contents are never observable.
    main_q <= main_d;
    skid_q <= skid_d;
  end

  // Present the main slot, or the idle/reset values when nothing is held.
  always_comb begin
    out_instr    = NOP_INSTR;
    out_pc       = '0;
    out_imm      = '0;
    out_imm_type = IMM_NONE;
    out_rs1      = '0;
    out_rs2      = '0;
    out_rd       = '0;
    out_illegal  = 1'b0;
    if (state_q != ST_EMPTY) begin
      out_instr    = main_q.instr;
      out_pc       = main_q.pc;
      out_imm      = main_q.imm;
      out_imm_type = main_q.imm_type;
      out_rs1      = main_q.rs1;
      out_rs2      = main_q.rs2;
      out_rd       = main_q.rd;
      out_illegal  = main_q.illegal;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: a queue-based reference model checked every
// cycle, plus literal expectations from hand-decoded instruction words.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    int          typ;
    logic        illegal;
  } exp_t;

  exp_t        model_q[$];
  logic [31:0] popped[$];
  logic [31:0] pc_next = 32'h0000_1000;

  id_decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the format tables.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic signed [11:0] imm12;
    logic signed [12:0] imm13;
    logic signed [20:0] imm21;
    e.instr = i; e.pc = pc; e.imm = 32'd0; e.typ = 0; e.illegal = 1'b0;
    if (i[1:0] != 2'b11) e.illegal = 1'b1;
    else begin
      case (i[6:0])
        7'h13, 7'h03, 7'h67, 7'h73: e.typ = 1;
        7'h23: e.typ = 2;
        7'h63: e.typ = 3;
        7'h37, 7'h17: e.typ = 4;
        7'h6F: e.typ = 5;
        7'h33: e.typ = 0;
        default: e.illegal = 1'b1;
      endcase
    end
    case (e.typ)
      1: begin imm12 = i[31:20]; e.imm = 32'(imm12); end
      2: begin imm12 = {i[31:25], i[11:7]}; e.imm = 32'(imm12); end
      3: begin imm13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; e.imm = 32'(imm13); end
      4: e.imm = i & 32'hFFFF_F000;
      5: begin imm21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; e.imm = 32'(imm21); end
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  // Reference occupancy: a two-deep FIFO of decoded records.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit acc, pp;
      acc = in_valid && (model_q.size() < 2);
      pp  = out_ready && (model_q.size() > 0);
      if (flush) model_q.delete();
      else begin
        if (pp) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_decode(in_instr, in_pc));
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle; also logs real pops.
  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    if (model_q.size() > 0) begin
      exp_t e;
      e = model_q[0];
      check("out_instr", out_instr, e.instr);
      check("out_pc", out_pc, e.pc);
      check("out_imm", out_imm, e.imm);
      check("out_imm_type", {29'd0, out_imm_type}, e.typ);
      check("out_rs1", {27'd0, out_rs1}, {27'd0, e.instr[19:15]});
      check("out_rs2", {27'd0, out_rs2}, {27'd0, e.instr[24:20]});
      check("out_rd", {27'd0, out_rd}, {27'd0, e.instr[11:7]});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
    end else begin
      check("idle_instr", out_instr, 32'h0000_0013);
      check("idle_pc", out_pc, 32'd0);
      check("idle_imm", out_imm, 32'd0);
      check("idle_type", {29'd0, out_imm_type}, 32'd0);
      check("idle_illegal", {31'd0, out_illegal}, 32'd0);
    end
    if (rst_n && !flush && out_valid && out_ready) popped.push_back(out_instr);
  end

  // Offer one instruction and hold it until accepted (bounded).
  task automatic offer(input logic [31:0] instr);
    bit got = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc_next;
    for (int k = 0; k < 20 && !got; k++) begin
      got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) check("offer_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    pc_next  = pc_next + 32'd4;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    rst_n = 1'b1;

    // Single pushes with out_ready held high; each is visible one edge later.
    offer(32'hFFF0_0093);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_type", {29'd0, out_imm_type}, 32'd1);
    check("addi_rd", {27'd0, out_rd}, 32'd1);
    check("addi_illegal", {31'd0, out_illegal}, 32'd0);
    offer(32'hFE11_2E23);
    check("sw_imm", out_imm, 32'hFFFF_FFFC);
    check("sw_type", {29'd0, out_imm_type}, 32'd2);
    check("sw_rs1", {27'd0, out_rs1}, 32'd2);
    check("sw_rs2", {27'd0, out_rs2}, 32'd1);
    offer(32'h0010_006F);
    check("jal_imm", out_imm, 32'h0000_0800);
    check("jal_type", {29'd0, out_imm_type}, 32'd5);
    offer(32'h1234_52B7);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_type", {29'd0, out_imm_type}, 32'd4);
    check("lui_rd", {27'd0, out_rd}, 32'd5);
    offer(32'h0020_8463);
    check("beq_imm", out_imm, 32'h0000_0008);
    check("beq_type", {29'd0, out_imm_type}, 32'd3);
    offer(32'h0020_81B3);
    check("add_type", {29'd0, out_imm_type}, 32'd0);
    check("add_illegal", {31'd0, out_illegal}, 32'd0);
    offer(32'h0000_007F);
    check("bad_illegal", {31'd0, out_illegal}, 32'd1);
    check("bad_imm", out_imm, 32'd0);
    check("bad_type", {29'd0, out_imm_type}, 32'd0);
    offer(32'hFFFF_FFF2);
    check("low_bits_illegal", {31'd0, out_illegal}, 32'd1);
    idle(2);
    check("drained_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: three offers, two fit, third waits for out_ready.
    out_ready = 1'b0;
    popped.delete();
    offer(32'h0010_0093);
    offer(32'h0020_0113);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_instr = 32'h0030_0193; in_pc = pc_next;
    @(posedge clk); #1;
    check("full_hold_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    offer(32'h0030_0193);
    idle(4);
    check("bp_count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      check("bp_order0", popped[0], 32'h0010_0093);
      check("bp_order1", popped[1], 32'h0020_0113);
      check("bp_order2", popped[2], 32'h0030_0193);
    end

    // Flush while full, with a simultaneous offer that must be dropped.
    out_ready = 1'b0;
    offer(32'h0040_0213);
    offer(32'h0050_0293);
    in_valid = 1'b1; in_instr = 32'h0DEA_D093; in_pc = pc_next; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    popped.delete();
    idle(3);
    check("flush_nothing_out", popped.size(), 32'd0);

    // Asynchronous reset while full, then resume.
    out_ready = 1'b0;
    offer(32'h0060_0313);
    offer(32'h0070_0393);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_instr", out_instr, 32'h0000_0013);
    check("arst_out_pc", out_pc, 32'd0);
    check("arst_out_imm", out_imm, 32'd0);
    check("arst_out_rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(32'h0050_0293);
    check("resume_imm", out_imm, 32'h0000_0005);
    check("resume_rd", {27'd0, out_rd}, 32'd5);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
